// File: rtl/cpu_sequencer_if.sv
// Bundle of control, ROM and debug signals between a host and cpu_sequencer.
// The master side drives start, the ROM word and the debug select; the slave is the sequencer.
interface cpu_sequencer_if #(
    parameter int unsigned DW = 16
);
    logic          start;
    logic [8:0]    instruction;
    logic [DW-1:0] data_var;
    logic          step;
    logic          busy;
    logic          done;
    logic          carry;
    logic [2:0]    rd_sel;
    logic [DW-1:0] rd_data;
    logic [7:0]    instr_count;

    modport master (
        output start, instruction, data_var, rd_sel,
        input  step, busy, done, carry, rd_data, instr_count
    );

    modport slave (
        input  start, instruction, data_var, rd_sel,
        output step, busy, done, carry, rd_data, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Four-clock-per-instruction sequencer for a small register machine fed by an external ROM.
// The ROM is advanced by a registered step strobe issued once per retired instruction.
module cpu_sequencer #(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 16
) (
    input logic            clk,
    input logic            reset,
    cpu_sequencer_if.slave bus
);
    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpMove = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpXor  = 3'b011;
    localparam logic [2:0] OpHalt = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StStep,
        StSettle,
        StHalt
    } state_e;

    state_e        state_q;
    logic [8:0]    ir_q;
    logic [DW-1:0] dr_q;
    logic [DW-1:0] regs_q [NREG];
    logic          step_q;
    logic          busy_q;
    logic          done_q;
    logic          carry_q;
    logic [7:0]    count_q;

    logic [2:0]    opcode;
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic [DW-1:0] op_x;
    logic [DW-1:0] op_y;
    logic [DW:0]   sum;

    // Operands come from the pre-write register file, so rx==ry aliasing reads old values.
    always_comb begin
        opcode = ir_q[8:6];
        rx     = ir_q[5:3];
        ry     = ir_q[2:0];
        op_x   = regs_q[rx];
        op_y   = regs_q[ry];
        sum    = {1'b0, op_x} + {1'b0, op_y};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ir_q    <= '0;
            dr_q    <= '0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            count_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StFetch;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    ir_q    <= bus.instruction;
                    dr_q    <= bus.data_var;
                    state_q <= StExec;
                end
                StExec: begin
                    if (opcode == OpHalt) begin
                        state_q <= StHalt;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StStep;
                        step_q  <= 1'b1;
                        count_q <= count_q + 8'd1;
                        case (opcode)
                            OpLoad: regs_q[rx] <= dr_q;
                            OpMove: regs_q[rx] <= op_y;
                            OpAdd: begin
                                regs_q[rx] <= sum[DW-1:0];
                                carry_q    <= sum[DW];
                            end
                            OpXor:   regs_q[rx] <= op_x ^ op_y;
                            default: ;
                        endcase
                    end
                end
                StStep: begin
                    step_q  <= 1'b0;
                    state_q <= StSettle;
                end
                StSettle: state_q <= StFetch;
                StHalt:   state_q <= StHalt;
                default: begin
                    state_q <= StIdle;
                    step_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.step        = step_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.carry       = carry_q;
    assign bus.instr_count = count_q;
    assign bus.rd_data     = regs_q[bus.rd_sel];
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: table of small programs run against a behavioural ROM,
// plus hand-written sequences for reset behaviour and write visibility.
module tb_cpu_sequencer;
    localparam logic [2:0] LD = 3'd0;
    localparam logic [2:0] MV = 3'd1;
    localparam logic [2:0] AD = 3'd2;
    localparam logic [2:0] XR = 3'd3;
    localparam logic [2:0] HL = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.DW(16)) bus ();
    cpu_sequencer #(.NREG(8), .DW(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    // ROM model: address advances on each rising edge of step and never rewinds on reset.
    int unsigned step_cnt = 0;
    int unsigned prog_base = 0;
    int unsigned rom_idx;
    logic [8:0]  rom_ins [8];
    logic [15:0] rom_dv  [8];
    always @(posedge bus.step) step_cnt = step_cnt + 1;
    always_comb begin
        rom_idx = step_cnt - prog_base;
        bus.instruction = {HL, 6'd0};
        bus.data_var    = 16'h0;
        if (rom_idx < 8) begin
            bus.instruction = rom_ins[rom_idx];
            bus.data_var    = rom_dv[rom_idx];
        end
    end

    typedef struct {
        string            name;
        logic [5:0][8:0]  ins;
        logic [5:0][15:0] dv;
        logic [2:0][2:0]  rsel;
        logic [2:0][15:0] rval;
        logic             carry;
        int               count;
        int               done_edge;
    } vec_t;

    vec_t vecs[6];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int v, input int k, input logic [2:0] op, input logic [2:0] rx,
                       input logic [2:0] ry, input logic [15:0] d);
        vecs[v].ins[k] = {op, rx, ry};
        vecs[v].dv[k]  = d;
    endtask

    task automatic want(input int v, input int k, input logic [2:0] r, input logic [15:0] val);
        vecs[v].rsel[k] = r;
        vecs[v].rval[k] = val;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_rom(input int v);
        for (int j = 0; j < 6; j++) begin
            rom_ins[j] = vecs[v].ins[j];
            rom_dv[j]  = vecs[v].dv[j];
        end
        rom_ins[6] = {HL, 6'd0};
        rom_ins[7] = {HL, 6'd0};
        rom_dv[6]  = 16'h0;
        rom_dv[7]  = 16'h0;
        prog_base  = step_cnt;
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
        bus.rd_sel = r;
        #1;
        val = bus.rd_data;
    endtask

    // Pulse start and watch each edge until done; returns the edge index done appeared on.
    task automatic run_to_done(input string name, input int exp_count, input int exp_done,
                               output int done_at);
        logic exp_step;
        done_at = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 100 && done_at == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) bus.start = 1'b0;
            exp_step = (n >= 3) && ((n - 3) % 4 == 0) && ((n - 3) / 4 < exp_count);
            check($sformatf("%s step@%0d", name, n), {31'd0, bus.step}, {31'd0, exp_step});
            check($sformatf("%s busy@%0d", name, n), {31'd0, bus.busy},
                  {31'd0, (n < exp_done)});
            if (bus.done === 1'b1) done_at = n;
        end
        check({name, " done_edge"}, done_at, exp_done);
    endtask

    task automatic run_vec(input int v);
        int          done_at;
        logic [15:0] rv;
        do_reset();
        load_rom(v);
        run_to_done(vecs[v].name, vecs[v].count, vecs[v].done_edge, done_at);
        for (int k = 0; k < 3; k++) begin
            read_reg(vecs[v].rsel[k], rv);
            check($sformatf("%s r%0d", vecs[v].name, vecs[v].rsel[k]), rv, vecs[v].rval[k]);
        end
        check({vecs[v].name, " carry"}, {31'd0, bus.carry}, {31'd0, vecs[v].carry});
        check({vecs[v].name, " count"}, bus.instr_count, vecs[v].count);
        check({vecs[v].name, " steps"}, step_cnt - prog_base, vecs[v].count);
        // HALT is terminal: a further start must change nothing.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check({vecs[v].name, " halt_done"}, {31'd0, bus.done}, 32'd1);
        check({vecs[v].name, " halt_busy"}, {31'd0, bus.busy}, 32'd0);
        check({vecs[v].name, " halt_steps"}, step_cnt - prog_base, vecs[v].count);
    endtask

    initial begin
        int          done_at;
        logic [15:0] rv;

        bus.start  = 1'b0;
        bus.rd_sel = 3'd0;
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 6; k++) put(v, k, HL, 3'd0, 3'd0, 16'h0);
            for (int k = 0; k < 3; k++) want(v, k, 3'd0, 16'h0);
            vecs[v].carry = 1'b0;
        end

        vecs[0].name = "prog_basic";
        put(0, 0, LD, 3'd0, 3'd0, 16'd9);
        put(0, 1, MV, 3'd1, 3'd0, 16'h0);
        put(0, 2, MV, 3'd2, 3'd0, 16'h0);
        put(0, 3, AD, 3'd1, 3'd0, 16'h0);
        put(0, 4, XR, 3'd2, 3'd1, 16'h0);
        want(0, 0, 3'd0, 16'd9); want(0, 1, 3'd1, 16'd18); want(0, 2, 3'd2, 16'd27);
        vecs[0].count = 5; vecs[0].done_edge = 23;

        vecs[1].name = "prog_carry";
        put(1, 0, LD, 3'd3, 3'd0, 16'hFFFF);
        put(1, 1, LD, 3'd4, 3'd0, 16'h0002);
        put(1, 2, AD, 3'd3, 3'd4, 16'h0);
        want(1, 0, 3'd3, 16'h0001); want(1, 1, 3'd4, 16'h0002); want(1, 2, 3'd0, 16'h0);
        vecs[1].carry = 1'b1; vecs[1].count = 3; vecs[1].done_edge = 15;

        vecs[2].name = "prog_alias";
        put(2, 0, LD, 3'd5, 3'd0, 16'h00F0);
        put(2, 1, AD, 3'd5, 3'd5, 16'h0);
        put(2, 2, XR, 3'd6, 3'd6, 16'h0);
        want(2, 0, 3'd5, 16'h01E0); want(2, 1, 3'd6, 16'h0); want(2, 2, 3'd7, 16'h0);
        vecs[2].count = 3; vecs[2].done_edge = 15;

        vecs[3].name = "prog_nop_xorclr";
        put(3, 0, LD, 3'd2, 3'd0, 16'h00AB);
        put(3, 1, LD, 3'd6, 3'd0, 16'h1234);
        put(3, 2, XR, 3'd6, 3'd6, 16'h0);
        put(3, 3, 3'b111, 3'd2, 3'd6, 16'hBEEF);
        want(3, 0, 3'd2, 16'h00AB); want(3, 1, 3'd6, 16'h0); want(3, 2, 3'd0, 16'h0);
        vecs[3].count = 4; vecs[3].done_edge = 19;

        // Carry from the add must survive the following non-add instructions.
        vecs[4].name = "prog_carry_hold";
        put(4, 0, LD, 3'd1, 3'd0, 16'hFFFF);
        put(4, 1, AD, 3'd1, 3'd1, 16'h0);
        put(4, 2, MV, 3'd0, 3'd1, 16'h0);
        put(4, 3, XR, 3'd0, 3'd1, 16'h0);
        put(4, 4, 3'b101, 3'd1, 3'd0, 16'h0);
        want(4, 0, 3'd1, 16'hFFFE); want(4, 1, 3'd0, 16'h0); want(4, 2, 3'd2, 16'h0);
        vecs[4].carry = 1'b1; vecs[4].count = 5; vecs[4].done_edge = 23;

        vecs[5].name = "prog_halt_first";
        vecs[5].count = 0; vecs[5].done_edge = 3;

        // Reset with start held high: reset wins, all outputs at reset values.
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst step", {31'd0, bus.step}, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst carry", {31'd0, bus.carry}, 32'd0);
        check("rst count", bus.instr_count, 32'd0);
        read_reg(3'd5, rv);
        check("rst r5", rv, 16'h0);
        bus.start = 1'b0;
        reset     = 1'b0;

        for (int v = 0; v < 6; v++) run_vec(v);

        // Write becomes visible on the edge that ends EXEC, not before.
        do_reset();
        put(0, 5, HL, 3'd0, 3'd0, 16'h0);
        rom_ins[0] = {LD, 3'd7, 3'd0}; rom_dv[0] = 16'h5A5A;
        for (int j = 1; j < 8; j++) begin
            rom_ins[j] = {HL, 6'd0};
            rom_dv[j]  = 16'h0;
        end
        prog_base  = step_cnt;
        bus.rd_sel = 3'd7;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        check("wr_vis before", bus.rd_data, 16'h0);
        @(posedge clk); #1;
        check("wr_vis after", bus.rd_data, 16'h5A5A);

        // Reset during the STEP clock of instruction 3, then resume from the ROM's address.
        do_reset();
        load_rom(0);
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.start = 1'b0;
        end
        check("midrst step_hi", {31'd0, bus.step}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst step", {31'd0, bus.step}, 32'd0);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst count", bus.instr_count, 32'd0);
        read_reg(3'd1, rv);
        check("midrst r1", rv, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst idle_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst rom_addr", step_cnt - prog_base, 32'd3);
        run_to_done("resume", 2, 11, done_at);
        check("resume count", bus.instr_count, 32'd2);
        check("resume rom_addr", step_cnt - prog_base, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
